// File: rtl/timer_keypad_entry.sv
// ---------------------------------------------------------------------------
// timer_keypad_entry
//
// Keypad time-entry and run-control stage for the countdown timer. Digit keys
// shift into a four-digit MM:SS entry register. CLEAR, START and STOP keys
// drive the parallel-load strobe and the active-low count enable of the
// downstream digit down-counter chain. A terminal count from that chain
// returns the block to entry mode.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous, active-low reset
//   key_valid    keypad key-down level (high while a key is held)
//   key_code     key code: 0-9 digit, 10 CLEAR, 11 START, 12 STOP, 13-15 none
//   timer_done   terminal-count flag from the counter chain
//   min_tens, min_ones, sec_tens, sec_ones
//                registered entry digits, fed to the counters' load inputs
//   load         one-cycle parallel-load strobe
//   enable_n     active-low count enable
//   digit_count  digits accepted since the entry register was emptied (0-4)
//   running      high while counting (state RUN)
// ---------------------------------------------------------------------------
module timer_keypad_entry (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       timer_done,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       load,
    output logic       enable_n,
    output logic [2:0] digit_count,
    output logic       running
);

    typedef enum logic [1:0] {
        ENTRY  = 2'd0,
        LOAD   = 2'd1,
        RUN    = 2'd2,
        PAUSED = 2'd3
    } state_t;

    localparam logic [3:0] KEY_CLEAR = 4'd10;
    localparam logic [3:0] KEY_START = 4'd11;
    localparam logic [3:0] KEY_STOP  = 4'd12;

    state_t state;
    logic   key_q;
    logic   key_event;
    logic   is_digit;
    logic   all_zero;

    // key_q resets to 1 so a key held through reset is not seen as a new press.
    assign key_event = key_valid & ~key_q;
    assign is_digit  = (key_code <= 4'd9);
    assign all_zero  = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                       (sec_tens == 4'd0) && (sec_ones == 4'd0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ENTRY;
            key_q       <= 1'b1;
            min_tens    <= 4'd0;
            min_ones    <= 4'd0;
            sec_tens    <= 4'd0;
            sec_ones    <= 4'd0;
            digit_count <= 3'd0;
            load        <= 1'b0;
            enable_n    <= 1'b1;
            running     <= 1'b0;
        end else begin
            key_q <= key_valid;
            load  <= 1'b0;

            case (state)
                ENTRY: begin
                    if (key_event) begin
                        if (is_digit) begin
                            if (digit_count < 3'd4) begin
                                // The first digit of a fresh entry wipes the
                                // digits retained from the previous run.
                                if (digit_count == 3'd0) begin
                                    min_tens <= 4'd0;
                                    min_ones <= 4'd0;
                                    sec_tens <= 4'd0;
                                end else begin
                                    min_tens <= min_ones;
                                    min_ones <= sec_tens;
                                    sec_tens <= sec_ones;
                                end
                                sec_ones    <= key_code;
                                digit_count <= digit_count + 3'd1;
                            end
                        end else if (key_code == KEY_CLEAR) begin
                            min_tens    <= 4'd0;
                            min_ones    <= 4'd0;
                            sec_tens    <= 4'd0;
                            sec_ones    <= 4'd0;
                            digit_count <= 3'd0;
                        end else if (key_code == KEY_START && !all_zero) begin
                            load        <= 1'b1;
                            digit_count <= 3'd0;
                            state       <= LOAD;
                        end
                    end
                end

                // One cycle so the counters load before their first enabled count.
                LOAD: begin
                    enable_n <= 1'b0;
                    running  <= 1'b1;
                    state    <= RUN;
                end

                RUN: begin
                    // Terminal count wins over any key event on the same edge.
                    if (timer_done) begin
                        enable_n <= 1'b1;
                        running  <= 1'b0;
                        state    <= ENTRY;
                    end else if (key_event && key_code == KEY_STOP) begin
                        enable_n <= 1'b1;
                        running  <= 1'b0;
                        state    <= PAUSED;
                    end else if (key_event && key_code == KEY_CLEAR) begin
                        enable_n    <= 1'b1;
                        running     <= 1'b0;
                        min_tens    <= 4'd0;
                        min_ones    <= 4'd0;
                        sec_tens    <= 4'd0;
                        sec_ones    <= 4'd0;
                        digit_count <= 3'd0;
                        state       <= ENTRY;
                    end
                end

                PAUSED: begin
                    // Resume without a load; the counters still hold their value.
                    if (key_event && key_code == KEY_START) begin
                        enable_n <= 1'b0;
                        running  <= 1'b1;
                        state    <= RUN;
                    end else if (key_event && key_code == KEY_CLEAR) begin
                        min_tens    <= 4'd0;
                        min_ones    <= 4'd0;
                        sec_tens    <= 4'd0;
                        sec_ones    <= 4'd0;
                        digit_count <= 3'd0;
                        state       <= ENTRY;
                    end
                end

                default: begin
                    state <= ENTRY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_keypad_entry.sv
// ---------------------------------------------------------------------------
// tb_timer_keypad_entry
//
// Directed testbench for timer_keypad_entry. Inputs change 1 time unit after
// each rising edge, and outputs are sampled at that same point. Every expected
// value below is worked out by hand from the block's behaviour.
// ---------------------------------------------------------------------------
module tb_timer_keypad_entry;

    logic       clk;
    logic       rst;
    logic       key_valid;
    logic [3:0] key_code;
    logic       timer_done;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       load;
    logic       enable_n;
    logic [2:0] digit_count;
    logic       running;

    int errors = 0;
    int checks = 0;
    int load_pulses;

    timer_keypad_entry dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .timer_done  (timer_done),
        .min_tens    (min_tens),
        .min_ones    (min_ones),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .load        (load),
        .enable_n    (enable_n),
        .digit_count (digit_count),
        .running     (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] digits();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    // Count one comparison and report it if the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then advance to just after the next rising edge.
    task automatic applyStimulus(input logic valid, input logic [3:0] code,
                                 input logic done);
        key_valid  = valid;
        key_code   = code;
        timer_done = done;
        @(posedge clk);
        #1;
    endtask

    // One key press: down for one edge, released for one edge.
    task automatic pressKey(input logic [3:0] code);
        applyStimulus(1'b1, code, 1'b0);
        applyStimulus(1'b0, code, 1'b0);
    endtask

    initial begin
        rst        = 1'b0;
        key_valid  = 1'b1;
        key_code   = 4'd5;
        timer_done = 1'b0;

        // Reset with a digit key held through it.
        applyStimulus(1'b1, 4'd5, 1'b0);
        applyStimulus(1'b1, 4'd5, 1'b0);
        checkOutput("reset_digits",   32'(digits()), 32'h0000);
        checkOutput("reset_count",    32'(digit_count), 0);
        checkOutput("reset_enable_n", 32'(enable_n), 1);
        checkOutput("reset_load",     32'(load), 0);
        checkOutput("reset_running",  32'(running), 0);

        rst = 1'b1;
        applyStimulus(1'b1, 4'd5, 1'b0);
        applyStimulus(1'b1, 4'd5, 1'b0);
        checkOutput("held_key_digits", 32'(digits()), 32'h0000);
        checkOutput("held_key_count",  32'(digit_count), 0);
        checkOutput("held_key_load",   32'(load), 0);
        applyStimulus(1'b0, 4'd0, 1'b0);

        // Entry and overflow: 1,2,3,0 then 7 ignored.
        pressKey(4'd1);
        checkOutput("entry1", 32'(digits()), 32'h0001);
        pressKey(4'd2);
        checkOutput("entry2", 32'(digits()), 32'h0012);
        pressKey(4'd3);
        checkOutput("entry3", 32'(digits()), 32'h0123);
        pressKey(4'd0);
        checkOutput("entry4",       32'(digits()), 32'h1230);
        checkOutput("entry4_count", 32'(digit_count), 4);
        pressKey(4'd7);
        checkOutput("overflow_digits", 32'(digits()), 32'h1230);
        checkOutput("overflow_count",  32'(digit_count), 4);

        // CLEAR, then START on an all-zero entry does nothing.
        pressKey(4'd10);
        checkOutput("clear_digits", 32'(digits()), 32'h0000);
        checkOutput("clear_count",  32'(digit_count), 0);
        applyStimulus(1'b1, 4'd11, 1'b0);
        checkOutput("zero_start_load", 32'(load), 0);
        applyStimulus(1'b0, 4'd0, 1'b0);
        checkOutput("zero_start_enable_n", 32'(enable_n), 1);
        checkOutput("zero_start_running",  32'(running), 0);

        // Enter 0130 and hold START for 10 cycles: one load pulse only.
        pressKey(4'd0);
        pressKey(4'd1);
        pressKey(4'd3);
        pressKey(4'd0);
        checkOutput("entry_0130", 32'(digits()), 32'h0130);
        applyStimulus(1'b1, 4'd11, 1'b0);
        checkOutput("start_load",       32'(load), 1);
        checkOutput("start_enable_n",   32'(enable_n), 1);
        checkOutput("start_count_zero", 32'(digit_count), 0);
        load_pulses = int'(load);
        applyStimulus(1'b1, 4'd11, 1'b0);
        checkOutput("run_load",     32'(load), 0);
        checkOutput("run_enable_n", 32'(enable_n), 0);
        checkOutput("run_running",  32'(running), 1);
        load_pulses += int'(load);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 4'd11, 1'b0);
            load_pulses += int'(load);
        end
        checkOutput("held_start_pulses", 32'(load_pulses), 1);
        applyStimulus(1'b0, 4'd0, 1'b0);

        // Terminal count returns to entry with digits kept.
        applyStimulus(1'b0, 4'd0, 1'b1);
        checkOutput("done_enable_n", 32'(enable_n), 1);
        checkOutput("done_running",  32'(running), 0);
        checkOutput("done_digits",   32'(digits()), 32'h0130);
        applyStimulus(1'b0, 4'd0, 1'b0);

        // First digit after a run starts a fresh entry.
        pressKey(4'd4);
        checkOutput("fresh_digit", 32'(digits()), 32'h0004);
        checkOutput("fresh_count", 32'(digit_count), 1);

        // Stop and resume without reloading.
        applyStimulus(1'b1, 4'd11, 1'b0);
        checkOutput("sr_start_load", 32'(load), 1);
        applyStimulus(1'b0, 4'd0, 1'b0);
        checkOutput("sr_run_enable_n", 32'(enable_n), 0);
        applyStimulus(1'b1, 4'd12, 1'b0);
        checkOutput("stop_enable_n", 32'(enable_n), 1);
        checkOutput("stop_running",  32'(running), 0);
        applyStimulus(1'b0, 4'd0, 1'b0);
        applyStimulus(1'b1, 4'd11, 1'b0);
        checkOutput("resume_enable_n", 32'(enable_n), 0);
        checkOutput("resume_running",  32'(running), 1);
        checkOutput("resume_load",     32'(load), 0);
        applyStimulus(1'b0, 4'd0, 1'b0);
        checkOutput("resume_load_after", 32'(load), 0);

        // timer_done and CLEAR together: done wins, digits kept.
        applyStimulus(1'b1, 4'd10, 1'b1);
        checkOutput("conflict_enable_n", 32'(enable_n), 1);
        checkOutput("conflict_running",  32'(running), 0);
        checkOutput("conflict_digits",   32'(digits()), 32'h0004);
        applyStimulus(1'b0, 4'd0, 1'b0);

        // Codes 13-15 are inert.
        pressKey(4'd13);
        pressKey(4'd14);
        pressKey(4'd15);
        checkOutput("inert_digits", 32'(digits()), 32'h0004);
        checkOutput("inert_count",  32'(digit_count), 0);

        // Entry 0075: sec_tens of 7 passes through to the load.
        pressKey(4'd0);
        pressKey(4'd0);
        pressKey(4'd7);
        pressKey(4'd5);
        checkOutput("entry_0075", 32'(digits()), 32'h0075);
        applyStimulus(1'b1, 4'd11, 1'b0);
        checkOutput("load_0075",    32'(load), 1);
        checkOutput("sec_tens_7",   32'(sec_tens), 7);
        applyStimulus(1'b0, 4'd0, 1'b0);
        checkOutput("run_0075", 32'(running), 1);

        // Reset in the middle of a run.
        rst = 1'b0;
        applyStimulus(1'b0, 4'd0, 1'b0);
        checkOutput("midrun_rst_enable_n", 32'(enable_n), 1);
        checkOutput("midrun_rst_running",  32'(running), 0);
        checkOutput("midrun_rst_digits",   32'(digits()), 32'h0000);
        rst = 1'b1;
        applyStimulus(1'b0, 4'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
